// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline constants: NOP/HALT encodings and the sequential PC step.
package pipeline_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF;
    localparam int unsigned PC_INCREMENT = 4;
endpackage

// File: rtl/pc_incrementer.sv
// Combinational PC + PC_INCREMENT adder; wraps modulo 2^NB.
module pc_incrementer
    import pipeline_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic [NB-1:0] i_pc,
    output logic [NB-1:0] o_pc_plus4
);
    assign o_pc_plus4 = i_pc + NB'(PC_INCREMENT);
endmodule

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with stall, flush, debug enable and fetch counter.
// Optional sticky HALT detection is built when IF_ID_HALT_DETECT_EN is defined.
module if_id_latch
    import pipeline_pkg::*;
#(
    parameter int NB     = 32,
    parameter int NB_CNT = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_if_id_write,
    input  logic              i_flush,
    input  logic [NB-1:0]     i_pc,
    input  logic [NB-1:0]     i_instruction,
    output logic [NB-1:0]     o_pc,
    output logic [NB-1:0]     o_pc_plus4,
    output logic [NB-1:0]     o_instruction,
    output logic              o_valid,
    output logic              o_halt,
    output logic [NB_CNT-1:0] o_fetch_count
);
    logic [NB-1:0]     pc_plus4;
    logic [NB-1:0]     pc_p1;
    logic [NB-1:0]     pc_plus4_p1;
    logic [NB-1:0]     instr_p1;
    logic              vld_p1;
    logic [NB_CNT-1:0] cnt_p1;
    logic              load_allowed;
    logic              do_load;
    logic              do_flush;

    pc_incrementer #(.NB(NB)) u_pc_incrementer (
        .i_pc       (i_pc),
        .o_pc_plus4 (pc_plus4)
    );

    assign do_flush = i_enable && i_flush;
    assign do_load  = i_enable && !i_flush && load_allowed && i_if_id_write;

`ifdef IF_ID_HALT_DETECT_EN
    logic halt_p1;

    // A latched HALT blocks further loads until a flush squashes it.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            halt_p1 <= 1'b0;
        end else if (do_flush) begin
            halt_p1 <= 1'b0;
        end else if (do_load) begin
            halt_p1 <= (i_instruction == NB'(HALT_INSTR));
        end
    end

    assign load_allowed = !halt_p1;
    assign o_halt       = halt_p1;
`else
    assign load_allowed = 1'b1;
    assign o_halt       = 1'b0;
`endif

    // IF -> ID stage boundary
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            pc_p1       <= '0;
            pc_plus4_p1 <= '0;
            instr_p1    <= NB'(NOP_INSTR);
            vld_p1      <= 1'b0;
            cnt_p1      <= '0;
        end else if (do_flush) begin
            instr_p1 <= NB'(NOP_INSTR);
            vld_p1   <= 1'b0;
        end else if (do_load) begin
            pc_p1       <= i_pc;
            pc_plus4_p1 <= pc_plus4;
            instr_p1    <= i_instruction;
            vld_p1      <= 1'b1;
            cnt_p1      <= cnt_p1 + NB_CNT'(1);
        end
    end

    assign o_pc          = pc_p1;
    assign o_pc_plus4    = pc_plus4_p1;
    assign o_instruction = instr_p1;
    assign o_valid       = vld_p1;
    assign o_fetch_count = cnt_p1;
endmodule
